seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of multiplexed digits.
REQ-002 SHALL have parameter STABLE, default 2, legal range 1..7: identical consecutive visits required to commit a digit.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port an, input, NDIG bits: digit select, active-high, expected one-hot or all-zero (blank).
REQ-006 SHALL have port seg, input, 7 bits: segment pattern, active-high, seg[6]=a ... seg[0]=g.
REQ-007 SHALL have port hex, output, 4*NDIG bits: decoded value, digit d in hex[4d+3:4d].
REQ-008 SHALL have port valid, output, NDIG bits: digit d holds a committed legal value.
REQ-009 SHALL have port err, output, NDIG bits: last committed pattern for digit d was illegal.
REQ-010 SHALL have port upd, output, 1 bit: one-cycle pulse when any hex/valid/err bit changes.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when every digit has been visited since the last pulse.
REQ-012 SHALL have port an_err, output, 1 bit: one-cycle pulse after a cycle with more than one an bit set.

Function
REQ-013 SHALL register an each cycle into prev_an (reset value 0).
REQ-014 SHALL define a visit to digit d as a cycle where an is one-hot with bit d set and an != prev_an; further cycles with the same an are not visits.
REQ-015 SHALL treat an == 0 as blanking: no visit, prev_an becomes 0, so re-selecting the same digit after a blank is a new visit.
REQ-016 SHALL, on a multi-hot an, perform no capture, update prev_an, and pulse an_err on the next cycle.
REQ-017 SHALL sample seg only in the visit cycle.
REQ-018 SHALL keep per digit a candidate pattern (7 bits) and a visit count saturating at STABLE.
REQ-019 SHALL, on a visit: if seg == candidate, increment count (saturating); else load candidate = seg and set count = 1.
REQ-020 SHALL commit when the count reaches STABLE on that visit (transition only; later matching visits do not recommit).
REQ-021 SHALL decode via the hex table 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47; every other pattern is illegal.
REQ-022 SHALL, on committing a legal pattern, set hex[d] to its code, valid[d]=1 and err[d]=0.
REQ-023 SHALL, on committing an illegal pattern, set err[d]=1 and valid[d]=0, leaving hex[d] unchanged.
REQ-024 SHALL make committed outputs visible on the clock edge after the visit cycle (latency 1 cycle).
REQ-025 SHALL pulse upd in the same cycle the changed outputs first appear; no pulse if a commit leaves hex, valid and err unchanged.
REQ-026 SHALL keep a seen mask of visited digits; when a visit completes the mask, pulse frame_done on the next cycle and clear the mask, including the completing bit.
REQ-027 SHALL treat STABLE=1 as committing on every visit whose pattern differs from the candidate, and on the first visit after reset.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, force hex=0, valid=0, err=0, upd=0, frame_done=0, an_err=0, prev_an=0, seen=0, all candidates=0 and counts=0.
REQ-029 SHALL, after reset is released mid-frame, treat the next selection of any digit as a fresh visit with count starting at 1.

Verification (NDIG=4, STABLE=2)
REQ-030 Reset: assert rst between edges -> all outputs 0 immediately, without waiting for a clock edge.
REQ-031 Scan digits 0..3 with seg 7E, 30, 6D, 79, 3 cycles each, two frames -> after frame 2: valid=1111, hex=16'h3210; frame_done pulses twice; upd pulses 4 times, all in frame 2.
REQ-032 Glitch: digit 1 shows 33 for one visit, then 30 for later visits -> hex[7:4] stays 1 and no upd is caused by digit 1.
REQ-033 Illegal pattern: digit 2 shows 00 for two visits -> err[2]=1, valid[2]=0, hex[11:8] stays 2, one upd pulse.
REQ-034 Select handling: an=0011 -> an_err pulses once with no state change; an=0001 held 10 cycles -> one visit; 0001,0000,0001 -> two visits.
REQ-035 Reset mid-frame after a digit 0 visit with 7E -> next single 7E visit does not commit; the second one commits with hex[3:0]=0.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Scanned 7-segment display bus: digit select and segment pattern in,
// decoded per-digit values and status pulses out.
interface seg7_scan_decoder_if #(parameter int NDIG = 4);
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic [4*NDIG-1:0] hex;
  logic [NDIG-1:0]   valid;
  logic [NDIG-1:0]   err;
  logic              upd;
  logic              frame_done;
  logic              an_err;

  modport master (output an, seg, input hex, valid, err, upd, frame_done, an_err);
  modport slave  (input an, seg, output hex, valid, err, upd, frame_done, an_err);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment scan: each digit's pattern
// must repeat on STABLE consecutive visits before it is committed.
module seg7_digit #(parameter int STABLE = 2) (
  input  logic       clk,
  input  logic       rst,
  input  logic       visit,
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       valid,
  output logic       err,
  output logic       chg
);
  logic [6:0] cand;
  logic [2:0] cnt, cnt_nx;
  logic       match, commit, legal;
  logic [3:0] code, hex_nx;
  logic       valid_nx, err_nx;

  // {legal, value}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h7E: return 5'h10;  7'h30: return 5'h11;  7'h6D: return 5'h12;  7'h79: return 5'h13;
      7'h33: return 5'h14;  7'h5B: return 5'h15;  7'h5F: return 5'h16;  7'h70: return 5'h17;
      7'h7F: return 5'h18;  7'h7B: return 5'h19;  7'h77: return 5'h1A;  7'h1F: return 5'h1B;
      7'h4E: return 5'h1C;  7'h3D: return 5'h1D;  7'h4F: return 5'h1E;  7'h47: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    match  = (seg == cand);
    cnt_nx = match ? ((cnt == 3'(STABLE)) ? cnt : cnt + 3'd1) : 3'd1;
    // a saturated matching visit is not a new commit
    commit = visit && (cnt_nx == 3'(STABLE)) && !(match && cnt == 3'(STABLE));
    {legal, code} = decode(seg);
    hex_nx   = hex;
    valid_nx = valid;
    err_nx   = err;
    if (commit) begin
      if (legal) begin
        hex_nx   = code;
        valid_nx = 1'b1;
        err_nx   = 1'b0;
      end else begin
        valid_nx = 1'b0;
        err_nx   = 1'b1;
      end
    end
    chg = ({hex_nx, valid_nx, err_nx} != {hex, valid, err});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand  <= '0;
      cnt   <= '0;
      hex   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (visit) begin
        cand <= seg;
        cnt  <= cnt_nx;
      end
      hex   <= hex_nx;
      valid <= valid_nx;
      err   <= err_nx;
    end
  end
endmodule

module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 2
) (
  input logic           clk,
  input logic           rst,
  seg7_scan_decoder_if.slave bus
);
  logic [NDIG-1:0]       prev_an, seen, seen_nx, visit, chg, valid_d, err_d;
  logic [NDIG-1:0][3:0]  hex_d;
  logic                  onehot, multi, upd_q, fd_q, ae_q;

  always_comb begin
    onehot  = (bus.an != '0) && ((bus.an & (bus.an - NDIG'(1))) == '0);
    multi   = (bus.an != '0) && !onehot;
    // a held select is one visit; blanking in between makes the next one fresh
    visit   = (onehot && (bus.an != prev_an)) ? bus.an : '0;
    seen_nx = seen | visit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_an <= '0;
      seen    <= '0;
      upd_q   <= 1'b0;
      fd_q    <= 1'b0;
      ae_q    <= 1'b0;
    end else begin
      prev_an <= bus.an;
      ae_q    <= multi;
      upd_q   <= |chg;
      fd_q    <= (visit != '0) && (&seen_nx);
      seen    <= (&seen_nx) ? '0 : seen_nx;
    end
  end

  for (genvar d = 0; d < NDIG; d++) begin : g_dig
    seg7_digit #(.STABLE(STABLE)) u_dig (
      .clk   (clk),
      .rst   (rst),
      .visit (visit[d]),
      .seg   (bus.seg),
      .hex   (hex_d[d]),
      .valid (valid_d[d]),
      .err   (err_d[d]),
      .chg   (chg[d])
    );
  end

  assign bus.hex        = hex_d;
  assign bus.valid      = valid_d;
  assign bus.err        = err_d;
  assign bus.upd        = upd_q;
  assign bus.frame_done = fd_q;
  assign bus.an_err     = ae_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scenarios plus randomized scanning against a run-length history model.
module tb_seg7_scan_decoder;
  localparam int NDIG = 4;
  localparam int STABLE = 2;
  localparam logic [6:0] CODES [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg7_scan_decoder_if #(.NDIG(NDIG)) bus ();

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int upd_n = 0, fd_n = 0, ae_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a digit commits when the run of identical patterns seen on its
  // visits since reset, ending at this visit, is exactly STABLE long.
  logic [15:0] m_hex = '0;
  logic [3:0]  m_valid = '0, m_err = '0, m_prev = '0, m_seen = '0;
  logic        m_upd = 1'b0, m_fd = 1'b0, m_ae = 1'b0;
  logic [6:0]  hist [NDIG][$];
  logic [23:0] m_old;
  int          m_d, m_run;
  bit          m_legal;
  logic [3:0]  m_code;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hex = '0; m_valid = '0; m_err = '0; m_prev = '0; m_seen = '0;
      m_upd = 0; m_fd = 0; m_ae = 0;
      for (int d = 0; d < NDIG; d++) hist[d].delete();
    end else begin
      m_old = {m_hex, m_valid, m_err};
      m_ae  = ($countones(bus.an) > 1);
      m_fd  = 1'b0;
      if ($countones(bus.an) == 1 && bus.an != m_prev) begin
        for (int d = 0; d < NDIG; d++) if (bus.an[d]) m_d = d;
        hist[m_d].push_back(bus.seg);
        m_run = 0;
        for (int i = hist[m_d].size() - 1; i >= 0 && hist[m_d][i] == bus.seg; i--) m_run++;
        if (m_run == STABLE) begin
          m_legal = 0;
          m_code = '0;
          for (int k = 0; k < 16; k++)
            if (CODES[k] == bus.seg) begin m_legal = 1; m_code = 4'(k); end
          if (m_legal) begin
            m_hex[4*m_d +: 4] = m_code;
            m_valid[m_d] = 1'b1;
            m_err[m_d] = 1'b0;
          end else begin
            m_valid[m_d] = 1'b0;
            m_err[m_d] = 1'b1;
          end
        end
        m_seen = m_seen | bus.an;
        if (m_seen == 4'hF) begin m_fd = 1'b1; m_seen = '0; end
      end
      m_upd  = (m_old != {m_hex, m_valid, m_err});
      m_prev = bus.an;
    end
  end

  always @(negedge clk) begin
    if (bus.upd) upd_n++;
    if (bus.frame_done) fd_n++;
    if (bus.an_err) ae_n++;
    if (chk_en) begin
      check("hex", 32'(bus.hex), 32'(m_hex));
      check("valid", 32'(bus.valid), 32'(m_valid));
      check("err", 32'(bus.err), 32'(m_err));
      check("upd", 32'(bus.upd), 32'(m_upd));
      check("frame_done", 32'(bus.frame_done), 32'(m_fd));
      check("an_err", 32'(bus.an_err), 32'(m_ae));
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bus.an = a;
      bus.seg = s;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame();
    drive(4'b0001, 7'h7E, 3);
    drive(4'b0010, 7'h30, 3);
    drive(4'b0100, 7'h6D, 3);
    drive(4'b1000, 7'h79, 3);
  endtask

  int b_upd, b_fd, b_ae, hold;
  logic [3:0] ra;
  logic [6:0] rs;
  logic [6:0] tgt [NDIG];

  initial begin
    bus.an = '0;
    bus.seg = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_hex", 32'(bus.hex), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_pulses", 32'({bus.upd, bus.frame_done, bus.an_err}), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // two frames of 0,1,2,3
    b_upd = upd_n; b_fd = fd_n;
    frame();
    check("frame1_upd", 32'(upd_n - b_upd), 32'd0);
    frame();
    check("frame2_upd", 32'(upd_n - b_upd), 32'd4);
    check("frame2_fd", 32'(fd_n - b_fd), 32'd2);
    check("frame2_hex", 32'(bus.hex), 32'h3210);
    check("frame2_valid", 32'(bus.valid), 32'hF);
    check("model_hex", 32'(m_hex), 32'h3210);

    // glitch on digit 1
    b_upd = upd_n;
    drive(4'b0010, 7'h33, 1); drive(4'b0000, 7'h00, 1);
    drive(4'b0010, 7'h30, 1); drive(4'b0000, 7'h00, 1);
    drive(4'b0010, 7'h30, 1); drive(4'b0000, 7'h00, 2);
    check("glitch_upd", 32'(upd_n - b_upd), 32'd0);
    check("glitch_hex1", 32'(bus.hex[7:4]), 32'h1);

    // illegal pattern on digit 2
    b_upd = upd_n;
    drive(4'b0100, 7'h00, 1); drive(4'b0000, 7'h00, 1);
    drive(4'b0100, 7'h00, 1); drive(4'b0000, 7'h00, 2);
    check("illegal_err2", 32'(bus.err[2]), 32'h1);
    check("illegal_valid2", 32'(bus.valid[2]), 32'h0);
    check("illegal_hex2", 32'(bus.hex[11:8]), 32'h2);
    check("illegal_upd", 32'(upd_n - b_upd), 32'd1);
    check("model_err", 32'(m_err), 32'h4);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_hex", 32'(bus.hex), 32'h0);
    check("async_rst_valid_err", 32'({bus.valid, bus.err}), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // select handling
    b_ae = ae_n;
    drive(4'b0011, 7'h7E, 1); drive(4'b0000, 7'h00, 2);
    check("multi_an_err", 32'(ae_n - b_ae), 32'd1);
    check("multi_nostate", 32'({bus.valid, bus.err}), 32'h0);
    drive(4'b0001, 7'h7E, 10); drive(4'b0000, 7'h00, 1);
    check("held_one_visit", 32'(bus.valid[0]), 32'h0);
    drive(4'b0001, 7'h7E, 1); drive(4'b0000, 7'h00, 1);
    check("reselect_visit", 32'(bus.valid[0]), 32'h1);
    check("reselect_hex0", 32'(bus.hex[3:0]), 32'h0);

    // reset mid-frame after a digit 0 visit
    drive(4'b0001, 7'h7E, 1); drive(4'b0000, 7'h00, 1);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    drive(4'b0001, 7'h7E, 1); drive(4'b0000, 7'h00, 1);
    check("midrst_first", 32'(bus.valid[0]), 32'h0);
    drive(4'b0001, 7'h7E, 1); drive(4'b0000, 7'h00, 1);
    check("midrst_second", 32'(bus.valid[0]), 32'h1);
    check("midrst_hex0", 32'(bus.hex[3:0]), 32'h0);

    // randomized scanning
    for (int d = 0; d < NDIG; d++) tgt[d] = CODES[$urandom_range(0, 15)];
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0, 1: ra = 4'b0000;
        9: begin
          ra = 4'(1 << $urandom_range(0, 3));
          ra = ra | 4'(1 << $urandom_range(0, 3));
          if ($countones(ra) < 2) ra = 4'b0110;
        end
        default: ra = 4'(1 << $urandom_range(0, 3));
      endcase
      for (int d = 0; d < NDIG; d++) begin
        if ($urandom_range(0, 11) == 0) tgt[d] = CODES[$urandom_range(0, 15)];
      end
      rs = 7'h00;
      for (int d = 0; d < NDIG; d++) if (ra[d]) rs = tgt[d];
      if ($urandom_range(0, 15) == 0) rs = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 3);
      drive(ra, rs, hold);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    drive(4'b0000, 7'h00, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
